// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 slave register bank with burst writes and per-register write strobes.
// Define SPI_READBACK_EN to serve read frames on cipo; otherwise cipo/cipo_oe are tied low.
module spi_regbank #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe
);
    localparam int MAX_W = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DATA = 3'd3, HOLD = 3'd4;

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0] hist_q, hist_d;
    logic [2:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic rw_q, rw_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] strobe_q, strobe_d;
    logic sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise, ncs_fall, step, last, word_done;

    assign {sclk_s, copi_s, ncs_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~hist_q[1];
    assign ncs_rise  = ncs_s & ~hist_q[0];
    assign ncs_fall  = ~ncs_s & hist_q[0];
    // ncs rising wins over a coincident sclk edge, so the bit is dropped
    assign step = sclk_rise & ~ncs_rise;
    assign last = cnt_q == CNT_W'(state_q == ADDR ? ADDR_W - 1 : DATA_W - 1);
    assign wr_strobe = strobe_q;

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sclk, copi, ncs};
        hist_d    = {sclk_s, ncs_s};
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rw_d      = rw_q;
        regs_d    = regs_q;
        strobe_d  = '0;
        word_done = 1'b0;
        if (ncs_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (ncs_fall) begin
                state_d = CMD;
                cnt_d   = '0;
                addr_d  = '0;
                data_d  = '0;
            end
        end else if (step && state_q == CMD) begin
            rw_d = copi_s;
`ifdef SPI_READBACK_EN
            state_d = ADDR;
`else
            state_d = copi_s ? ADDR : HOLD;
`endif
        end else if (step && state_q == ADDR) begin
            addr_d  = ADDR_W'({addr_q, copi_s});
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            state_d = last ? DATA : ADDR;
        end else if (step && state_q == DATA) begin
            data_d    = DATA_W'({data_q, copi_s});
            cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
            addr_d    = last ? addr_q + ADDR_W'(1) : addr_q;
            word_done = last;
        end
        // out-of-range addresses match no register and are silently dropped
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_done && rw_q && addr_q == ADDR_W'(i)) begin
                regs_d[i]   = data_d;
                strobe_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hist_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rw_q     <= 1'b0;
            regs_q   <= '{default: '0};
            strobe_q <= '0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] sout_q, sout_d;
    logic cipo_q, cipo_d, sclk_fall, load;

    assign sclk_fall = ~sclk_s & hist_q[1];
    assign load      = step && last && !rw_q && (state_q == ADDR || state_q == DATA);
    assign cipo      = cipo_q;
    assign cipo_oe   = !rw_q && (state_q == ADDR || state_q == DATA);

    always_comb begin
        sout_d = sout_q;
        cipo_d = cipo_q;
        if (ncs_rise || state_q == IDLE) begin
            sout_d = '0;
            cipo_d = 1'b0;
        end else if (load) begin
            sout_d = '0;
            for (int i = 0; i < NUM_REGS; i++)
                if (addr_d == ADDR_W'(i)) sout_d = regs_q[i];
        end else if (sclk_fall && state_q == DATA && !rw_q) begin
            cipo_d = sout_q[DATA_W-1];
            sout_d = sout_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout_q <= '0;
            cipo_q <= 1'b0;
        end else begin
            sout_q <= sout_d;
            cipo_q <= cipo_d;
        end
    end
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: directed vector bench for spi_regbank (default parameters).
module tb_spi_regbank;
    localparam int H = 6;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic cipo, cipo_oe;
    logic [39:0] regs_o;
    logic [4:0] wr_strobe;

    int tests = 0, fails = 0;
    int pulse_cnt [5] = '{default: 0};
    int wide = 0;
    logic [4:0] prev_strobe = '0;
    logic [7:0] rd_sh;
    logic oe_acc;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        int          nbits;
        logic [39:0] exp_regs;
        logic [4:0]  exp_strobe;
        int          exp_pulses;
    } vec_t;
    vec_t vecs [5];

    spi_regbank dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_o(regs_o), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) if (wr_strobe[i]) pulse_cnt[i]++;
        if (wr_strobe != 0 && prev_strobe != 0) wide++;
        prev_strobe = wr_strobe;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        copi = b;
        repeat (H) @(negedge clk);
        rd_sh  = {rd_sh[6:0], cipo};
        oe_acc = oe_acc & cipo_oe;
        sclk = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic start_frame;
        ncs = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic stop_frame;
        repeat (H) @(negedge clk);
        ncs = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic snap(output int s [5]);
        s = pulse_cnt;
    endtask

    task automatic strobe_diff(input int s [5], output logic [4:0] mask, output int total);
        mask = '0;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            mask[i] = pulse_cnt[i] != s[i];
            total += pulse_cnt[i] - s[i];
        end
    endtask

    task automatic write1(input logic [6:0] a, input logic [7:0] d);
        start_frame();
        send_bits({24'd0, 1'b1, a}, 8);
        send_bits({24'd0, d}, 8);
        stop_frame();
    endtask

    initial begin
        int s [5];
        logic [4:0] mask;
        int total;

        vecs[0] = '{7'd2,   8'hA5, 8, 40'h0000A50000, 5'b00100, 1};
        vecs[1] = '{7'd1,   8'hFF, 5, 40'h0000A50000, 5'b00000, 0};
        vecs[2] = '{7'd1,   8'h3C, 8, 40'h0000A53C00, 5'b00010, 1};
        vecs[3] = '{7'h7F,  8'h99, 8, 40'h0000A53C00, 5'b00000, 0};
        vecs[4] = '{7'd0,   8'hFF, 8, 40'h0000A53CFF, 5'b00001, 1};

        repeat (4) @(negedge clk);
        chk("reset_regs", 64'(regs_o), 64'h0);
        chk("reset_strobe", 64'(wr_strobe), 64'h0);
        chk("reset_cipo", 64'(cipo), 64'h0);
        chk("reset_cipo_oe", 64'(cipo_oe), 64'h0);
        rst_n = 1'b1;
        repeat (2 * H) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            snap(s);
            start_frame();
            send_bits({24'd0, 1'b1, vecs[v].addr}, 8);
            send_bits(32'(vecs[v].data >> (8 - vecs[v].nbits)), vecs[v].nbits);
            stop_frame();
            strobe_diff(s, mask, total);
            chk($sformatf("vec%0d_regs", v), 64'(regs_o), 64'(vecs[v].exp_regs));
            chk($sformatf("vec%0d_strobe", v), 64'(mask), 64'(vecs[v].exp_strobe));
            chk($sformatf("vec%0d_pulses", v), 64'(total), 64'(vecs[v].exp_pulses));
        end

        snap(s);
        start_frame();
        send_bits({24'd0, 1'b1, 7'd3}, 8);
        send_bits(32'h112233, 24);
        stop_frame();
        strobe_diff(s, mask, total);
        chk("burst_regs", 64'(regs_o), 64'h2211A53CFF);
        chk("burst_strobe", 64'(mask), 64'(5'b11000));
        chk("burst_pulses", 64'(total), 64'd2);

        write1(7'd4, 8'hC3);
        chk("wr4_regs", 64'(regs_o), 64'hC311A53CFF);

        start_frame();
        send_bits({24'd0, 1'b0, 7'd4}, 8);
        oe_acc = 1'b1;
        rd_sh = '0;
        send_bits(32'd0, 8);
`ifdef SPI_READBACK_EN
        chk("read_data", 64'(rd_sh), 64'hC3);
        chk("read_oe", 64'(oe_acc), 64'h1);
`else
        chk("read_data", 64'(rd_sh), 64'h0);
        chk("read_oe", 64'(oe_acc), 64'h0);
`endif
        stop_frame();
        chk("post_read_oe", 64'(cipo_oe), 64'h0);
        chk("post_read_cipo", 64'(cipo), 64'h0);
        chk("post_read_regs", 64'(regs_o), 64'hC311A53CFF);

        write1(7'd0, 8'h5A);
        chk("wr0_regs", 64'(regs_o), 64'hC311A53C5A);

        snap(s);
        start_frame();
        send_bits({24'd0, 1'b1, 7'd0}, 8);
        send_bits(32'b101, 3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_regs", 64'(regs_o), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bits(32'b00101, 5);
        stop_frame();
        strobe_diff(s, mask, total);
        chk("after_reset_regs", 64'(regs_o), 64'h0);
        chk("after_reset_pulses", 64'(total), 64'd0);

        write1(7'd0, 8'h5A);
        chk("final_regs", 64'(regs_o), 64'h000000005A);
        chk("strobe_width", 64'(wide), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
